// File: rtl/si_to_soe_hr_param.sv
// Simultaneous-input to series-of-elements converter: latches a NUM_ELEM-wide vector, replays it as HR chunks.
// Build option: define SOE_ZERO_IDLE_EN to force O to zero whenever outReady is low.
module si_to_soe_hr_param #(
    parameter int IN_WIDTH = 10,
    parameter int NUM_ELEM = 12,
    parameter int HR       = 3
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic                                 inReady,
    input  logic [NUM_ELEM*IN_WIDTH-1:0]         A,
    output logic                                 inAccept,
    output logic                                 newInSeriesStart,
    output logic [(NUM_ELEM/HR)*IN_WIDTH-1:0]    O,
    output logic [((HR > 1) ? $clog2(HR) : 1)-1:0] outSeries,
    output logic                                 outReady,
    output logic                                 earlyOutReady
);
    localparam int CHUNK = NUM_ELEM / HR;
    localparam int SW    = (HR > 1) ? $clog2(HR) : 1;
    localparam int CW    = CHUNK * IN_WIDTH;
    localparam int AW    = NUM_ELEM * IN_WIDTH;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [SW-1:0] series_q, series_d;
    logic [AW-1:0] hold_q, hold_d;
    logic [CW-1:0] o_q, o_d;
    logic          nis_q, nis_d;
    logic          last;
    logic          accept;

    assign last          = (series_q == SW'(HR - 1));
    assign inAccept      = (state_q == ST_IDLE) || last;
    assign accept        = enable && inReady && inAccept;
    assign earlyOutReady = accept;
    assign outReady      = (state_q == ST_EMIT) && enable;
    assign outSeries     = series_q;
    assign newInSeriesStart = nis_q;

    always_comb begin
        state_d  = state_q;
        series_d = series_q;
        hold_d   = hold_q;
        o_d      = o_q;
        nis_d    = nis_q;
        if (enable) begin
            if (accept) begin
                hold_d   = A;
                series_d = '0;
                state_d  = ST_EMIT;
            end else if (state_q == ST_EMIT) begin
                if (last) begin
                    series_d = '0;
                    state_d  = ST_IDLE;
                end else begin
                    series_d = series_q + 1'b1;
                end
            end
            // O is registered so the last chunk stays visible after the series ends
            if (state_d == ST_EMIT)
                o_d = hold_d[int'(series_d)*CW +: CW];
            nis_d = (series_d == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            series_q <= '0;
            hold_q   <= '0;
            o_q      <= '0;
            nis_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            series_q <= series_d;
            hold_q   <= hold_d;
            o_q      <= o_d;
            nis_q    <= nis_d;
        end
    end

`ifdef SOE_ZERO_IDLE_EN
    assign O = outReady ? o_q : '0;
`else
    assign O = o_q;
`endif

endmodule
